// File: rtl/usb_packet_tx_pkg.sv
// Shared PID, SYNC and CRC16 constants plus FSM state type for the USB packet transmitter.
package usb_packet_tx_pkg;

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [7:0]  SYNC_BYTE  = 8'h80;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    function automatic logic [15:0] reflect16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    // Bits leave LSB first, so the CRC register shifts right with the mirrored polynomial.
    localparam logic [15:0] CRC16_POLY_REFL = reflect16(CRC16_POLY);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SYNC, ST_PID, ST_DATA, ST_CRC_LO, ST_CRC_HI, ST_EOP, ST_IFG
    } tx_state_t;

    // Anything other than DATA0/DATA1 goes out as a bare handshake.
    function automatic logic is_data_pid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

endpackage

// File: rtl/usb_packet_tx_crc16.sv
// Serial reflected CRC16 (USB data CRC); one payload bit per enable, LSB first.
module usb_crc16
    import usb_packet_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || clear)
            crc <= CRC16_INIT;
        else if (en)
            crc <= (crc >> 1) ^ ((crc[0] ^ bit_in) ? CRC16_POLY_REFL : 16'h0000);
    end

endmodule

// File: rtl/usb_packet_tx.sv
// Full-speed USB packet transmitter: SYNC, PID, payload, CRC16, EOP with bit stuffing and NRZI.
// Optional inter-packet gap after EOP enabled by defining USB_TX_IFG_EN.
module usb_packet_tx
    import usb_packet_tx_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int IFG_BITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_packet_start,
    input  logic [3:0] tx_packet_pid,
    output logic       tx_transaction_avail,
    input  logic [7:0] tx_packet_byte,
    input  logic       tx_packet_not_finished,
    output logic       tx_byte_req,
    output logic       usb_dp_tx,
    output logic       usb_dn_tx,
    output logic       usb_tx_oe
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = ($clog2(IFG_BITS) > 3) ? $clog2(IFG_BITS) : 3;

    tx_state_t        state, nxt_state;
    logic [DIV_W-1:0] div;
    logic [7:0]       shreg, nxt_shreg;
    logic [CNT_W-1:0] bit_cnt, nxt_cnt;
    logic [2:0]       ones_cnt, ones_next;
    logic [3:0]       pid_q;
    logic             stuffing, nxt_stuff;
    logic             level;
    logic             tick, counting, need_stuff, cur_bit, nxt_bit, data_pid;
    logic             crc_adv;
    logic [15:0]      crc;

    assign tick       = (state != ST_IDLE) && (div == DIV_W'(CLK_DIV - 1));
    assign counting   = (state == ST_SYNC) || (state == ST_PID) || (state == ST_DATA) ||
                        (state == ST_CRC_LO) || (state == ST_CRC_HI);
    assign cur_bit    = stuffing ? 1'b0 : shreg[0];
    assign ones_next  = (counting && cur_bit) ? ones_cnt + 3'd1 : 3'd0;
    assign need_stuff = counting && (ones_next == 3'd6);
    assign data_pid   = is_data_pid(pid_q);

    // Next bit decision, evaluated every cycle but only committed on tick.
    always_comb begin
        nxt_state   = state;
        nxt_shreg   = shreg;
        nxt_cnt     = bit_cnt;
        nxt_stuff   = 1'b0;
        crc_adv     = 1'b0;
        tx_byte_req = 1'b0;
        if (need_stuff) begin
            nxt_stuff = 1'b1;
        end else if (counting && bit_cnt != CNT_W'(7)) begin
            nxt_shreg = {1'b0, shreg[7:1]};
            nxt_cnt   = bit_cnt + 1'b1;
            crc_adv   = (state == ST_DATA);
        end else begin
            nxt_cnt = '0;
            case (state)
                ST_SYNC: begin
                    nxt_state = ST_PID;
                    nxt_shreg = {~pid_q, pid_q};
                end
                ST_PID, ST_DATA: begin
                    if (state == ST_PID && !data_pid) begin
                        nxt_state = ST_EOP;
                    end else if (tx_packet_not_finished) begin
                        nxt_state   = ST_DATA;
                        nxt_shreg   = tx_packet_byte;
                        crc_adv     = 1'b1;
                        tx_byte_req = tick;
                    end else begin
                        nxt_state = ST_CRC_LO;
                        nxt_shreg = ~crc[7:0];
                    end
                end
                ST_CRC_LO: begin
                    nxt_state = ST_CRC_HI;
                    nxt_shreg = ~crc[15:8];
                end
                ST_CRC_HI: nxt_state = ST_EOP;
                ST_EOP: begin
                    if (bit_cnt == CNT_W'(2)) begin
`ifdef USB_TX_IFG_EN
                        nxt_state = ST_IFG;
`else
                        nxt_state = ST_IDLE;
`endif
                    end else begin
                        nxt_cnt = bit_cnt + 1'b1;
                    end
                end
`ifdef USB_TX_IFG_EN
                ST_IFG: begin
                    if (bit_cnt == CNT_W'(IFG_BITS - 1)) nxt_state = ST_IDLE;
                    else nxt_cnt = bit_cnt + 1'b1;
                end
`endif
                default: nxt_state = ST_IDLE;
            endcase
        end
        nxt_bit = nxt_stuff ? 1'b0 : nxt_shreg[0];
    end

    // CRC is advanced as each payload bit is put on the line, so it is final when CRC_LO loads.
    usb_crc16 u_crc (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == ST_IDLE),
        .en     (tick && crc_adv),
        .bit_in (nxt_shreg[0]),
        .crc    (crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= ST_IDLE;
            div                  <= '0;
            shreg                <= '0;
            bit_cnt              <= '0;
            ones_cnt             <= '0;
            stuffing             <= 1'b0;
            pid_q                <= '0;
            level                <= 1'b1;
            usb_dp_tx            <= 1'b1;
            usb_dn_tx            <= 1'b0;
            usb_tx_oe            <= 1'b0;
            tx_transaction_avail <= 1'b1;
        end else if (state == ST_IDLE) begin
            div <= '0;
            if (tx_packet_start && tx_transaction_avail) begin
                state                <= ST_SYNC;
                pid_q                <= tx_packet_pid;
                shreg                <= SYNC_BYTE;
                bit_cnt              <= '0;
                ones_cnt             <= '0;
                stuffing             <= 1'b0;
                tx_transaction_avail <= 1'b0;
                usb_tx_oe            <= 1'b1;
                // SYNC starts with a 0, so the line leaves J for K immediately.
                level                <= 1'b0;
                usb_dp_tx            <= 1'b0;
                usb_dn_tx            <= 1'b1;
            end
        end else begin
            div <= (div == DIV_W'(CLK_DIV - 1)) ? '0 : div + 1'b1;
            if (tick) begin
                state    <= nxt_state;
                shreg    <= nxt_shreg;
                bit_cnt  <= nxt_cnt;
                stuffing <= nxt_stuff;
                ones_cnt <= need_stuff ? 3'd0 : ones_next;
                if (nxt_state == ST_EOP) begin
                    level                  <= 1'b1;
                    {usb_dp_tx, usb_dn_tx} <= (nxt_cnt == CNT_W'(2)) ? 2'b10 : 2'b00;
                end else if (nxt_state == ST_IDLE || nxt_state == ST_IFG) begin
                    level                  <= 1'b1;
                    {usb_dp_tx, usb_dn_tx} <= 2'b10;
                    usb_tx_oe              <= 1'b0;
                    tx_transaction_avail   <= (nxt_state == ST_IDLE);
                end else if (!nxt_bit) begin
                    level                  <= ~level;
                    {usb_dp_tx, usb_dn_tx} <= level ? 2'b01 : 2'b10;
                end
            end
        end
    end

endmodule
